// File: rtl/pc_sequencer_if.sv
// Bus between the controller and pc_sequencer: program control, the branch LUT hookup and status.
// Optional PC_BR_STATS_EN adds the BrCnt taken-branch counter.
interface pc_sequencer_if #(
  parameter int D = 12,
  parameter int A = 5,
  parameter int C = 16
);
  // Handshake: there is no valid/ready pair. Start is a one-cycle pulse that is
  // taken only in IDLE or DONE. Stall, Halt, BrTaken and BrIdx describe the
  // current instruction and are sampled on every RUN cycle. LutTarget must
  // answer LutAddr combinationally in the same cycle.
  logic         Start;
  logic [D-1:0] StartPC;
  logic         Stall;
  logic         Halt;
  logic         BrTaken;
  logic [A-1:0] BrIdx;
  logic [A-1:0] LutAddr;
  logic [D-1:0] LutTarget;
  logic [D-1:0] PC;
  logic         Running;
  logic         Done;
  logic         Fault;
  logic [C-1:0] CycleCnt;
  logic [1:0]   state_dbg;
`ifdef PC_BR_STATS_EN
  logic [C-1:0] BrCnt;

  modport master (
    output Start, StartPC, Stall, Halt, BrTaken, BrIdx, LutTarget,
    input  LutAddr, PC, Running, Done, Fault, CycleCnt, state_dbg, BrCnt
  );
  modport slave (
    input  Start, StartPC, Stall, Halt, BrTaken, BrIdx, LutTarget,
    output LutAddr, PC, Running, Done, Fault, CycleCnt, state_dbg, BrCnt
  );
`else
  modport master (
    output Start, StartPC, Stall, Halt, BrTaken, BrIdx, LutTarget,
    input  LutAddr, PC, Running, Done, Fault, CycleCnt, state_dbg
  );
  modport slave (
    input  Start, StartPC, Stall, Halt, BrTaken, BrIdx, LutTarget,
    output LutAddr, PC, Running, Done, Fault, CycleCnt, state_dbg
  );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE lifecycle, LUT-indexed branches, stall, halt and fault.
// Optional macro PC_BR_STATS_EN adds a saturating taken-branch counter (BrCnt).
module pc_sequencer #(
  parameter int D = 12,
  parameter int A = 5,
  parameter int C = 16
) (
  input  logic         Clk,
  input  logic         Reset_n,
  pc_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state_q;
  logic [D-1:0] pc_q;
  logic         fault_q;
  logic [C-1:0] cyc_cnt_q;
  logic [C-1:0] cyc_cnt_d;

  assign cyc_cnt_d = (cyc_cnt_q == '1) ? cyc_cnt_q : cyc_cnt_q + C'(1);

`ifdef PC_BR_STATS_EN
  logic [C-1:0] br_cnt_q;
  logic [C-1:0] br_cnt_d;
  assign br_cnt_d  = (br_cnt_q == '1) ? br_cnt_q : br_cnt_q + C'(1);
  assign bus.BrCnt = br_cnt_q;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      fault_q   <= 1'b0;
      cyc_cnt_q <= '0;
`ifdef PC_BR_STATS_EN
      br_cnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // DONE holds everything until a re-run is requested.
          if (bus.Start) begin
            state_q   <= S_RUN;
            pc_q      <= bus.StartPC;
            fault_q   <= 1'b0;
            cyc_cnt_q <= '0;
`ifdef PC_BR_STATS_EN
            br_cnt_q  <= '0;
`endif
          end
        end
        S_RUN: begin
          cyc_cnt_q <= cyc_cnt_d;
          if (bus.Halt) begin
            state_q <= S_DONE;
          end else if (bus.Stall) begin
            // Branch presented with a stall is dropped; the controller repeats it.
            state_q <= S_RUN;
          end else if (bus.BrTaken && (bus.BrIdx != '0)) begin
            pc_q <= bus.LutTarget;
`ifdef PC_BR_STATS_EN
            br_cnt_q <= br_cnt_d;
`endif
          end else if (bus.BrTaken) begin
            // LUT index 0 is reserved, so a branch through it is illegal.
            fault_q <= 1'b1;
            state_q <= S_DONE;
          end else if (pc_q == '1) begin
            fault_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            pc_q <= pc_q + D'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.LutAddr   = (state_q == S_RUN) ? bus.BrIdx : '0;
  assign bus.PC        = pc_q;
  assign bus.Running   = (state_q == S_RUN);
  assign bus.Done      = (state_q == S_DONE);
  assign bus.Fault     = fault_q;
  assign bus.CycleCnt  = cyc_cnt_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer: lifecycle, branches, priority, faults, reset and saturation.
module tb_pc_sequencer;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  pc_sequencer_if #(.D(12), .A(5), .C(16)) bus ();
  pc_sequencer_if #(.D(12), .A(5), .C(4))  bus4 ();

  pc_sequencer #(.D(12), .A(5), .C(16)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus.slave)
  );

  pc_sequencer #(.D(12), .A(5), .C(4)) dut4 (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus4.slave)
  );

  // Branch-target LUT model; entry 0 returns 0.
  logic [11:0] lut [32];
  assign bus.LutTarget  = lut[bus.LutAddr];
  assign bus4.LutTarget = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Start   = 1'b0;
    bus.Stall   = 1'b0;
    bus.Halt    = 1'b0;
    bus.BrTaken = 1'b0;
    bus.BrIdx   = '0;
  endtask

  task automatic start_prog(input logic [11:0] spc);
    bus.StartPC = spc;
    bus.Start   = 1'b1;
    tick();
    bus.Start   = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 32; i++) lut[i] = 12'(i * 16);
    lut[0] = '0;
    lut[1] = 12'd200;
    lut[3] = 12'd48;
    idle_inputs();
    bus.StartPC  = '0;
    bus4.Start   = 1'b0;
    bus4.StartPC = '0;
    bus4.Stall   = 1'b0;
    bus4.Halt    = 1'b0;
    bus4.BrTaken = 1'b0;
    bus4.BrIdx   = '0;
    rst_n = 1'b0;
    #23;
    rst_n = 1'b1;
    tick();

    // Reset state, and LutAddr forced to 0 outside RUN
    bus.BrIdx = 5'd5;
    #1;
    check_eq("rst_pc", bus.PC, 0);
    check_eq("rst_running", bus.Running, 0);
    check_eq("rst_done", bus.Done, 0);
    check_eq("rst_fault", bus.Fault, 0);
    check_eq("rst_cnt", bus.CycleCnt, 0);
    check_eq("idle_lutaddr", bus.LutAddr, 0);
    bus.BrIdx = '0;

    // Sequential run from 0
    start_prog(12'd0);
    check_eq("seq_pc0", bus.PC, 0);
    check_eq("seq_running", bus.Running, 1);
    check_eq("seq_cnt0", bus.CycleCnt, 0);
    bus.BrIdx = 5'd9;
    #1;
    check_eq("run_lutaddr", bus.LutAddr, 9);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_eq("seq_pc", bus.PC, 32'(i));
    end
    check_eq("seq_cnt5", bus.CycleCnt, 5);
    tick();
    tick();
    check_eq("pre_br_pc", bus.PC, 7);

    // Taken branch via LUT index 3 -> 48
    bus.BrTaken = 1'b1;
    bus.BrIdx   = 5'd3;
    tick();
    check_eq("br_pc", bus.PC, 48);
    bus.BrTaken = 1'b0;
    tick();
    check_eq("br_next_pc", bus.PC, 49);
`ifdef PC_BR_STATS_EN
    check_eq("br_cnt1", bus.BrCnt, 1);
`endif

    // Stall beats branch for two cycles, counter keeps running
    bus.Stall   = 1'b1;
    bus.BrTaken = 1'b1;
    bus.BrIdx   = 5'd1;
    tick();
    tick();
    check_eq("stall_pc", bus.PC, 49);
    check_eq("stall_cnt", bus.CycleCnt, 11);
    check_eq("stall_running", bus.Running, 1);

    // Halt beats branch
    bus.Stall = 1'b0;
    bus.Halt  = 1'b1;
    tick();
    check_eq("halt_done", bus.Done, 1);
    check_eq("halt_running", bus.Running, 0);
    check_eq("halt_pc", bus.PC, 49);
    check_eq("halt_cnt", bus.CycleCnt, 12);
    check_eq("halt_fault", bus.Fault, 0);
    idle_inputs();
    tick();
    check_eq("done_hold_cnt", bus.CycleCnt, 12);
    check_eq("done_hold_pc", bus.PC, 49);

    // Illegal branch through index 0
    start_prog(12'd10);
    check_eq("rerun_pc", bus.PC, 10);
    bus.BrTaken = 1'b1;
    bus.BrIdx   = 5'd0;
    tick();
    check_eq("idx0_fault", bus.Fault, 1);
    check_eq("idx0_done", bus.Done, 1);
    check_eq("idx0_pc", bus.PC, 10);
    check_eq("idx0_cnt", bus.CycleCnt, 1);
    bus.BrTaken = 1'b0;
    bus.BrIdx   = 5'd6;
    #1;
    check_eq("done_lutaddr", bus.LutAddr, 0);
    bus.BrIdx = '0;

    // PC overflow at top of range
    start_prog(12'd4095);
    check_eq("top_pc", bus.PC, 4095);
    check_eq("top_fault0", bus.Fault, 0);
    tick();
    check_eq("top_fault", bus.Fault, 1);
    check_eq("top_pc_hold", bus.PC, 4095);
    check_eq("top_done", bus.Done, 1);

    // Restart from a faulted DONE clears fault and counters
    start_prog(12'd100);
    check_eq("restart_fault", bus.Fault, 0);
    check_eq("restart_cnt", bus.CycleCnt, 0);
    check_eq("restart_pc", bus.PC, 100);
    check_eq("restart_running", bus.Running, 1);
`ifdef PC_BR_STATS_EN
    check_eq("restart_brcnt", bus.BrCnt, 0);
`endif
    bus.StartPC = 12'd500;
    bus.Start   = 1'b1;
    tick();
    bus.Start   = 1'b0;
    check_eq("start_in_run_pc", bus.PC, 101);
    check_eq("start_in_run_cnt", bus.CycleCnt, 1);

    // Reset asserted mid-run takes effect without a clock
    bus.Halt = 1'b1;
    tick();
    bus.Halt = 1'b0;
    start_prog(12'd18);
    tick();
    tick();
    check_eq("mid_pc20", bus.PC, 20);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_pc", bus.PC, 0);
    check_eq("async_running", bus.Running, 0);
    check_eq("async_cnt", bus.CycleCnt, 0);
    bus.StartPC = 12'd7;
    bus.Start   = 1'b1;
    tick();
    check_eq("held_rst_running", bus.Running, 0);
    check_eq("held_rst_pc", bus.PC, 0);
    bus.Start = 1'b0;
    rst_n = 1'b1;
    tick();
    start_prog(12'd3);
    check_eq("post_rst_running", bus.Running, 1);
    check_eq("post_rst_pc", bus.PC, 3);

    // Cycle counter saturation on a 4-bit counter
    bus4.StartPC = 12'd0;
    bus4.Start   = 1'b1;
    tick();
    bus4.Start   = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check_eq("sat_cnt14", bus4.CycleCnt, 14);
    for (int i = 0; i < 6; i++) tick();
    check_eq("sat_cnt15", bus4.CycleCnt, 15);
    check_eq("sat_pc", bus4.PC, 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter sequencer that drives the branch-target lookup table: it supplies the lookup index and consumes the returned absolute target.
- Sits between the decoder/controller and instruction memory.
- Handles the program start/run/done lifecycle, sequential fetch, LUT-indexed taken branches, stall, halt, fault detection and a saturating cycle counter.

Parameters:
- D, 12, PC width; must equal the LUT target width.
- A, 5, LUT index width.
- C, 16, cycle-counter width.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  start pulse; honoured only in IDLE or DONE.
- StartPC  in  D  first PC of the program to run.
- Stall  in  1  hold the PC this cycle (RUN only).
- Halt  in  1  current instruction is a halt (RUN only).
- BrTaken  in  1  current instruction is a taken branch.
- BrIdx  in  A  branch-target LUT index for the current instruction.
- LutAddr  out  A  index driven to the LUT.
- LutTarget  in  D  absolute target returned by the LUT, combinational in the same cycle.
- PC  out  D  current program counter, registered.
- Running  out  1  high while in RUN.
- Done  out  1  high while in DONE.
- Fault  out  1  sticky error flag.
- CycleCnt  out  C  number of RUN cycles in the current program.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (Reset_n low, asynchronous, also when asserted mid-run):
  - state=IDLE; PC=0; Running=0; Done=0; Fault=0; CycleCnt=0.
  - Reset takes effect immediately, with no clock needed.
  - Outputs stay at these values while Reset_n is low.
- Running = (state==RUN); Done = (state==DONE). Both are decoded from the state register.
- LutAddr = BrIdx when state==RUN, else 0. It is combinational; the LUT returns 0 for index 0.
- IDLE:
  - Start=1 → PC<=StartPC, CycleCnt<=0, Fault<=0, next state RUN.
  - All other inputs are ignored.
- RUN: CycleCnt increments every cycle and saturates at 2^C-1. The next PC is chosen in this priority order:
  - 1. Halt=1 → PC holds, next state DONE. Halt overrides Stall and BrTaken in the same cycle.
  - 2. Stall=1 → PC holds, state stays RUN. A BrTaken in the same cycle is ignored; the controller re-presents it.
  - 3. BrTaken=1 and BrIdx!=0 → PC<=LutTarget. Latency is 1 cycle: the new PC is visible on the next edge.
  - 4. BrTaken=1 and BrIdx==0 → Fault<=1, PC holds, next state DONE. Index 0 is reserved and marks an illegal branch.
  - 5. Otherwise, if PC==2^D-1 → Fault<=1, PC holds, next state DONE. There is no wrap-around.
  - 6. Otherwise PC<=PC+1.
- Start while in RUN is ignored.
- DONE:
  - PC, Fault and CycleCnt hold.
  - Start=1 → PC<=StartPC, CycleCnt<=0, Fault<=0, next state RUN (re-run without reset).
- A LutTarget equal to the current PC is legal and forms a self-loop. The block does no range check on LutTarget.

Optional Feature:
- Macro: PC_BR_STATS_EN.
- When defined:
  - Adds output BrCnt [C-1:0]: number of taken branches (priority case 3) in the current program.
  - BrCnt saturates at 2^C-1.
  - BrCnt resets to 0 on Reset_n and clears on an accepted Start.
- When undefined:
  - No BrCnt port and no counter logic.
  - All other behaviour is identical.

Test Plan:
- Reset mid-run: assert Reset_n=0 while PC=20 in RUN → PC=0, Running=0, CycleCnt=0 immediately; Start after release → RUN.
- Sequential run: Start with StartPC=0, run 5 cycles, no branch → PC=0,1,2,3,4,5; CycleCnt=5; Running=1; LutAddr=BrIdx.
- Taken branch: at PC=7, BrTaken=1, BrIdx=3, LUT returns 48 → PC=48 next cycle. BrTaken=0 then → PC=49. With PC_BR_STATS_EN, BrCnt=1.
- Stall/halt priority: Stall=1 with BrTaken=1, BrIdx=1 → PC holds for 2 cycles, CycleCnt still increments. Then Halt=1 with BrTaken=1 → DONE, Done=1, PC unchanged.
- Faults:
  - BrTaken=1, BrIdx=0 → Fault=1, DONE, PC unchanged.
  - Separately, StartPC=4095 with no branch → Fault=1 after 1 cycle, PC stays 4095.
- Restart and saturation: from DONE with Fault=1, Start with StartPC=100 → Fault=0, CycleCnt=0, PC=100, RUN. Start pulsed during RUN → no effect. With C=4, 20 RUN cycles → CycleCnt=15.
